pll_lock_manager: RTL and testbench
===================================

Name: pll_lock_manager

Overview:
Supervises a multi-output PLL and sequences reset release for the clock domains fed by that PLL. It drives the PLL reset and synchronises the asynchronous PLL locked flag. It debounces lock, then releases per-domain reset requests in staged order. On lock loss or timeout it recovers automatically by re-resetting the PLL, with bounded retries. It sits between each PLL wrapper and the design's per-domain reset synchronisers, running on the PLL reference clock.

Parameters:
NUM_CLOCKS, 3, number of PLL output domains; width of domain_rst; range 1..18
PLL_RST_CYC, 32, refclk cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT_CYC, 65536, cycles allowed in WAIT_LOCK before the attempt is retried
LOCK_STABLE_CYC, 1024, consecutive synchronised-lock cycles required before release
STAGE_GAP_CYC, 16, cycles between release of domain_rst[i-1] and domain_rst[i]
MAX_RETRIES, 4, consecutive failed lock attempts before FAILED
CNT_W, 8, width of lock_lost_cnt

Ports:
refclk  in  1  reference clock; the only clock in this block
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked flag; asynchronous to refclk
sw_relock  in  1  single-cycle request to restart the PLL bring-up
pll_rst  out  1  reset to the PLL; active high
domain_rst  out  NUM_CLOCKS  per-domain reset requests; active high; bit i belongs to PLL outclk_i
ready  out  1  high only when all domains are released and lock is held
fail  out  1  high in FAILED state
lock_lost_cnt  out  CNT_W  saturating count of lock losses seen in RUN

Behaviour:
- Reset (rst=1, asynchronous): state=PLL_RESET, pll_rst=1, domain_rst all 1, ready=0, fail=0, lock_lost_cnt=0. All timers, the retry count and the stage index are 0. The synchroniser flops are 0.
- pll_locked passes through a 2-flop synchroniser to produce locked_s, adding 2 cycles of latency. Only locked_s is used internally.
- All outputs are registered. An output change is visible on the cycle after the condition is sampled.
- PLL_RESET: pll_rst=1, domain_rst all 1, ready=0. The timer counts up. After PLL_RST_CYC cycles the block moves to WAIT_LOCK and clears the timer.
- WAIT_LOCK: pll_rst=0.
  - If locked_s=1, move to STABLE and clear the timer.
  - Otherwise the timer increments. When the timer reaches LOCK_TIMEOUT_CYC-1, retry increments.
  - If retry then equals MAX_RETRIES, move to FAILED; otherwise move to PLL_RESET.
- STABLE: locked_s must be 1 for LOCK_STABLE_CYC consecutive cycles.
  - If locked_s drops, return to WAIT_LOCK with the timer cleared. retry does not change.
  - When the count completes, clear retry and move to RELEASE with stage=0.
- RELEASE: domain_rst[0] falls on the cycle after entry. domain_rst[i] falls STAGE_GAP_CYC cycles after domain_rst[i-1].
  - After the last bit falls, move to RUN. ready rises in the same cycle as the last domain_rst bit falls.
  - If NUM_CLOCKS=1, there is no gap.
  - Released bits stay low; they are never re-asserted individually.
- RUN: ready=1.
  - If locked_s falls: all domain_rst go to 1 and ready goes to 0 on the next cycle. lock_lost_cnt increments, saturating at all-ones. Move to PLL_RESET.
  - A lock drop during RELEASE behaves the same way, but lock_lost_cnt does not increment.
- FAILED: pll_rst=1, domain_rst all 1, ready=0, fail=1. The block stays here until sw_relock or rst.
- sw_relock: in any state it forces PLL_RESET with timers and retry cleared and fail cleared. It does not change lock_lost_cnt.
- sw_relock coincident with a lock drop in RUN: go to PLL_RESET and increment lock_lost_cnt (the loss is counted).
- sw_relock while already in PLL_RESET restarts the PLL_RST_CYC count.
- rst asserted mid-operation forces all outputs to their reset values immediately (asynchronously) and does not wait for a clock edge.
- Timers are sized $clog2 of the largest cycle parameter + 1. They never wrap, because each is cleared on every state entry.

Test Plan:
Bench parameters for all scenarios: NUM_CLOCKS=3, PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=50, LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, MAX_RETRIES=2.
- Nominal bring-up: release rst; set pll_locked=1 at the first cycle pll_rst is low.
  - pll_rst is high for exactly 4 cycles.
  - domain_rst[0] falls 2+8+1 cycles after pll_locked rises.
  - domain_rst[1] falls 4 cycles after [0]; domain_rst[2] falls 4 cycles after [1].
  - ready=1 on the same cycle as [2]; fail=0.
- Lock glitch in STABLE: drop pll_locked for 1 cycle at debounce count 5.
  - No domain_rst bit falls.
  - The debounce count restarts and the full 8 cycles are required afterwards.
  - pll_rst is not re-asserted.
- Lock loss in RUN: from ready=1, drop pll_locked.
  - 3 cycles later, domain_rst=3'b111, ready=0, pll_rst=1, lock_lost_cnt=1.
  - Restoring lock repeats the nominal sequence.
- Timeout and fail: hold pll_locked=0.
  - Two pll_rst pulses of 4 cycles each occur, separated by 50-cycle waits.
  - Then fail=1 and pll_rst stays 1.
  - A 1-cycle sw_relock pulse clears fail, and a 4-cycle pll_rst pulse follows.
- Saturation and simultaneity with CNT_W=2: force 5 lock losses in RUN, the last one coincident with sw_relock.
  - lock_lost_cnt reads 1, 2, 3, 3, 3.
- Async reset mid-RELEASE: assert rst between domain_rst[0] and domain_rst[1] releases, off a clock edge.
  - Outputs return to reset values before the next refclk edge: domain_rst=3'b111, pll_rst=1, lock_lost_cnt=0.

Source files
------------

// File: rtl/pll_lock_manager.sv
// PLL supervisor: holds the PLL in reset, debounces its synchronised lock flag, then
// releases the per-domain resets one stage at a time and recovers on lock loss or timeout.
module pll_lock_manager #(
    parameter int NUM_CLOCKS       = 3,
    parameter int PLL_RST_CYC      = 32,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGE_GAP_CYC    = 16,
    parameter int MAX_RETRIES      = 4,
    parameter int CNT_W            = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  sw_relock,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] domain_rst,
    output logic                  ready,
    output logic                  fail,
    output logic [CNT_W-1:0]      lock_lost_cnt
);

    localparam int MAX_AB  = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CD  = (LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int STAGE_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1;

    localparam logic [TMR_W-1:0]   RST_LAST     = TMR_W'(PLL_RST_CYC - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMR_W-1:0]   GAP_LAST     = TMR_W'(STAGE_GAP_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [STAGE_W-1:0] LAST_STAGE   = STAGE_W'(NUM_CLOCKS - 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAILED
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [RETRY_W-1:0]    retry_q, retry_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_CLOCKS-1:0] domain_rst_q, domain_rst_d;
    logic                  ready_q, ready_d;
    logic                  fail_q, fail_d;
    logic [CNT_W-1:0]      lost_q, lost_d;
    logic [CNT_W-1:0]      lost_inc;
    logic                  locked_s;

    assign locked_s = sync_q[1];
    assign lost_inc = (lost_q == {CNT_W{1'b1}}) ? lost_q : lost_q + 1'b1;

    always_comb begin
        sync_d       = {sync_q[0], pll_locked};
        state_d      = state_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        stage_d      = stage_q;
        domain_rst_d = domain_rst_q;
        lost_d       = lost_q;

        if (sw_relock) begin
            // A loss seen on the same edge as a software restart is still counted.
            state_d = ST_PLL_RESET;
            timer_d = '0;
            retry_d = '0;
            stage_d = '0;
            if (state_q == ST_RUN && !locked_s) begin
                lost_d = lost_inc;
            end
        end else begin
            case (state_q)
                ST_PLL_RESET: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAILED : ST_PLL_RESET;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        // Domain 0 is released on the same edge the debounce completes.
                        timer_d         = '0;
                        retry_d         = '0;
                        stage_d         = '0;
                        domain_rst_d[0] = 1'b0;
                        state_d         = (NUM_CLOCKS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_d = ST_PLL_RESET;
                        timer_d = '0;
                        stage_d = '0;
                    end else if (timer_q == GAP_LAST) begin
                        timer_d               = '0;
                        stage_d               = stage_q + 1'b1;
                        domain_rst_d[stage_d] = 1'b0;
                        if (stage_d == LAST_STAGE) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_PLL_RESET;
                        timer_d = '0;
                        stage_d = '0;
                        lost_d  = lost_inc;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_PLL_RESET;
                    timer_d = '0;
                end
            endcase
        end

        if (state_d != ST_RELEASE && state_d != ST_RUN) begin
            domain_rst_d = '1;
        end
        pll_rst_d = (state_d == ST_PLL_RESET) || (state_d == ST_FAILED);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAILED);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PLL_RESET;
            sync_q       <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            stage_q      <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            lost_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            stage_q      <= stage_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fail_q       <= fail_d;
            lost_q       <= lost_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign domain_rst    = domain_rst_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_lock_manager.sv
// Self-checking bench for pll_lock_manager: directed vector table, hand-written corner
// sequences and a randomized run, all compared every cycle against a behavioural model.
module tb_pll_lock_manager;

    localparam int NC  = 3;
    localparam int PRC = 4;
    localparam int LTO = 50;
    localparam int LSC = 8;
    localparam int SGC = 4;
    localparam int MR  = 2;
    localparam int CW  = 2;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_relock = 1'b0;
    logic          pll_rst;
    logic [NC-1:0] domain_rst;
    logic          ready;
    logic          fail;
    logic [CW-1:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_manager #(
        .NUM_CLOCKS(NC), .PLL_RST_CYC(PRC), .LOCK_TIMEOUT_CYC(LTO),
        .LOCK_STABLE_CYC(LSC), .STAGE_GAP_CYC(SGC), .MAX_RETRIES(MR), .CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .sw_relock(sw_relock),
        .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fail(fail),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    // Model phases: release and run are one phase; how many domains are out follows from elapsed time.
    localparam int M_RST = 0, M_WAIT = 1, M_STABLE = 2, M_LIVE = 3, M_FAILED = 4;
    int m_mode, m_el, m_retry, m_lost;
    bit m_hist[$];

    function automatic int released(input int el);
        int r;
        r = 1 + el / SGC;
        return (r > NC) ? NC : r;
    endfunction

    function automatic void model_reset();
        m_mode = M_RST; m_el = 0; m_retry = 0; m_lost = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endfunction

    function automatic void model_step();
        bit ls;
        bit all_out;
        int lost_max;
        ls = m_hist.pop_front();
        m_hist.push_back(pll_locked);
        all_out  = (m_mode == M_LIVE) && (released(m_el) == NC);
        lost_max = (1 << CW) - 1;
        if (sw_relock) begin
            if (all_out && !ls && m_lost < lost_max) m_lost++;
            m_mode = M_RST; m_el = 0; m_retry = 0;
        end else begin
            case (m_mode)
                M_RST: begin
                    m_el++;
                    if (m_el >= PRC) begin m_mode = M_WAIT; m_el = 0; end
                end
                M_WAIT: begin
                    if (ls) begin m_mode = M_STABLE; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el >= LTO) begin
                            m_retry++;
                            m_mode = (m_retry >= MR) ? M_FAILED : M_RST;
                            m_el = 0;
                        end
                    end
                end
                M_STABLE: begin
                    if (!ls) begin m_mode = M_WAIT; m_el = 0; end
                    else begin
                        m_el++;
                        if (m_el >= LSC) begin m_mode = M_LIVE; m_el = 0; m_retry = 0; end
                    end
                end
                M_LIVE: begin
                    if (!ls) begin
                        if (all_out && m_lost < lost_max) m_lost++;
                        m_mode = M_RST; m_el = 0;
                    end else m_el++;
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [NC+CW+2:0] model_out();
        logic p, r, f;
        logic [NC-1:0] d;
        int n;
        p = (m_mode == M_RST) || (m_mode == M_FAILED);
        f = (m_mode == M_FAILED);
        d = '1;
        r = 1'b0;
        if (m_mode == M_LIVE) begin
            n = released(m_el);
            for (int i = 0; i < n; i++) d[i] = 1'b0;
            r = (n == NC);
        end
        return {p, d, r, f, CW'(m_lost)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        check("model", {pll_rst, domain_rst, ready, fail, lock_lost_cnt}, model_out());
    endtask

    task automatic run_while(input logic lvl, input int bound, output int n);
        n = 0;
        while (pll_rst === lvl && n < bound) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        bit            locked;
        int            cycles;
        logic [NC-1:0] drst;
        bit            rdy;
        bit            prst;
        logic [CW-1:0] cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input bit lk, input int cy, input logic [NC-1:0] dr,
                                    input bit rd, input bit pr, input logic [CW-1:0] ct);
        vec_t v;
        v.locked = lk; v.cycles = cy; v.drst = dr; v.rdy = rd; v.prst = pr; v.cnt = ct;
        vecs.push_back(v);
    endfunction

    function automatic void add_bringup(input logic [CW-1:0] ct);
        add_vec(1, 10, 3'b111, 0, 0, ct);
        add_vec(1, 1,  3'b110, 0, 0, ct);
        add_vec(1, 3,  3'b110, 0, 0, ct);
        add_vec(1, 1,  3'b100, 0, 0, ct);
        add_vec(1, 3,  3'b100, 0, 0, ct);
        add_vec(1, 1,  3'b000, 1, 0, ct);
        add_vec(1, 5,  3'b000, 1, 0, ct);
    endfunction

    logic [CW-1:0] exp_cnt[5];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit ok;
        model_reset();
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // Reset state.
        repeat (2) @(negedge refclk);
        check("reset_state", {pll_rst, domain_rst, ready, fail, lock_lost_cnt}, {1'b1, 3'b111, 1'b0, 1'b0, 2'd0});
        rst = 1'b0;
        model_reset();

        // Nominal bring-up, lock loss in RUN, then a second bring-up.
        run_while(1'b1, 20, n);
        check("init_pll_rst_width", n, PRC);
        add_bringup(2'd0);
        add_vec(0, 2, 3'b000, 1, 0, 2'd0);
        add_vec(0, 1, 3'b111, 0, 1, 2'd1);
        add_vec(0, 3, 3'b111, 0, 1, 2'd1);
        add_vec(0, 1, 3'b111, 0, 0, 2'd1);
        add_bringup(2'd1);
        foreach (vecs[i]) begin
            pll_locked = vecs[i].locked;
            repeat (vecs[i].cycles) tick();
            check($sformatf("vec%0d", i), {pll_rst, domain_rst, ready, fail, lock_lost_cnt},
                  {vecs[i].prst, vecs[i].drst, vecs[i].rdy, 1'b0, vecs[i].cnt});
        end

        // One-cycle lock glitch during debounce (count 5) restarts the full debounce.
        sw_relock = 1'b1; tick(); sw_relock = 1'b0;
        repeat (PRC) tick();
        check("glitch_pll_rst_low", pll_rst, 1'b0);
        repeat (4) tick();
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            tick();
            if (domain_rst !== 3'b111 || pll_rst !== 1'b0) ok = 1'b0;
        end
        check("glitch_hold", ok, 1'b1);
        tick();
        check("glitch_release", domain_rst, 3'b110);
        repeat (10) tick();
        check("glitch_ready", ready, 1'b1);

        // Timeouts exhaust the retries, then software relock recovers.
        pll_locked = 1'b0; sw_relock = 1'b1; tick(); sw_relock = 1'b0;
        run_while(1'b1, 20, n);  check("to_pulse1", n, PRC);
        run_while(1'b0, 200, n); check("to_wait1", n, LTO);
        run_while(1'b1, 20, n);  check("to_pulse2", n, PRC);
        run_while(1'b0, 200, n); check("to_wait2", n, LTO);
        check("to_failed", {fail, pll_rst}, 2'b11);
        repeat (20) tick();
        check("to_failed_hold", {fail, pll_rst}, 2'b11);
        sw_relock = 1'b1; tick(); sw_relock = 1'b0;
        check("relock_clears_fail", fail, 1'b0);
        run_while(1'b1, 20, n);  check("relock_pulse", n, PRC);

        // Asynchronous reset between the domain 0 and domain 1 releases.
        pll_locked = 1'b1;
        n = 0;
        while (domain_rst !== 3'b110 && n < 60) begin tick(); n++; end
        check("ar_reach_release", domain_rst, 3'b110);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1 check("ar_outputs", {pll_rst, domain_rst, ready, fail, lock_lost_cnt}, {1'b1, 3'b111, 1'b0, 1'b0, 2'd0});
        model_reset();
        @(negedge refclk);
        rst = 1'b0;

        // Counter saturation; the last loss coincides with sw_relock.
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (ready !== 1'b1 && n < 200) begin tick(); n++; end
            check($sformatf("sat_ready%0d", i), ready, 1'b1);
            pll_locked = 1'b0;
            tick(); tick();
            if (i == 4) sw_relock = 1'b1;
            tick();
            sw_relock = 1'b0;
            check($sformatf("sat_cnt%0d", i), {ready, lock_lost_cnt}, {1'b0, exp_cnt[i]});
            pll_locked = 1'b1;
        end

        // Randomized lock activity and relock requests against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
            sw_relock = ($urandom_range(0, 199) == 0);
            tick();
        end
        sw_relock = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
